// File: rtl/snitch_tcdm_bank_arbiter.sv
// Shares one fixed-latency TCDM bank port between NumReq requesters.
// Priority-aware round-robin with starvation escalation and a latency-matched response tag pipeline.
module snitch_tcdm_bank_arbiter #(
    parameter int unsigned NumReq                = 2,
    parameter int unsigned AddrWidth             = 10,
    parameter int unsigned DataWidth             = 64,
    parameter int unsigned UserWidth             = 1,
    parameter int unsigned MemoryResponseLatency = 1,
    parameter int unsigned MaxStarve             = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumReq-1:0]               req_valid_i,
    output logic [NumReq-1:0]               req_ready_o,
    input  logic [NumReq-1:0]               req_prio_i,
    input  logic [NumReq*AddrWidth-1:0]     req_addr_i,
    input  logic [NumReq-1:0]               req_write_i,
    input  logic [NumReq*DataWidth-1:0]     req_data_i,
    input  logic [NumReq*(DataWidth/8)-1:0] req_strb_i,
    input  logic [NumReq*UserWidth-1:0]     req_user_i,
    output logic [NumReq-1:0]               rsp_valid_o,
    output logic [DataWidth-1:0]            rsp_data_o,
    output logic                            mem_valid_o,
    input  logic                            mem_ready_i,
    output logic [AddrWidth-1:0]            mem_addr_o,
    output logic                            mem_write_o,
    output logic [DataWidth-1:0]            mem_data_o,
    output logic [(DataWidth/8)-1:0]        mem_strb_o,
    output logic [UserWidth-1:0]            mem_user_o,
    input  logic [DataWidth-1:0]            mem_rdata_i
);

    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam int unsigned IdxWidth  = $clog2(NumReq);
    localparam int unsigned CntWidth  = $clog2(MaxStarve + 1);
    localparam int unsigned Lat       = MemoryResponseLatency;

    if (NumReq < 2) begin : g_bad_num_req
        $error("NumReq must be >= 2");
    end
    if (MemoryResponseLatency < 1) begin : g_bad_latency
        $error("MemoryResponseLatency must be >= 1");
    end
    if (MaxStarve < 1) begin : g_bad_max_starve
        $error("MaxStarve must be >= 1");
    end

    typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_e;

    state_e                        r_state;
    state_e                        w_state_d;
    logic [IdxWidth-1:0]           r_gnt_q;
    logic [IdxWidth-1:0]           r_rr_ptr;
    logic [CntWidth-1:0]           r_starve_cnt [NumReq];
    logic [Lat-1:0]                r_tag_vld;
    logic [Lat-1:0][IdxWidth-1:0]  r_tag_idx;

    logic [NumReq-1:0]             w_starved;
    logic [NumReq-1:0]             w_cand;
    logic [IdxWidth-1:0]           w_arb_gnt;
    logic [IdxWidth-1:0]           w_gnt;
    logic [IdxWidth:0]             w_gnt_inc;
    logic                          w_mem_valid;
    logic                          w_hs;

    logic [AddrWidth-1:0]          w_addr [NumReq];
    logic [DataWidth-1:0]          w_data [NumReq];
    logic [StrbWidth-1:0]          w_strb [NumReq];
    logic [UserWidth-1:0]          w_user [NumReq];

    // Rotate candidates so the scan starts at ptr, then map the first hit back to an index.
    function automatic logic [IdxWidth-1:0] f_rr_pick(input logic [NumReq-1:0] cand,
                                                      input logic [IdxWidth-1:0] ptr);
        logic [2*NumReq-1:0] dbl;
        logic [NumReq-1:0]   rot;
        logic [IdxWidth:0]   off;
        logic [IdxWidth:0]   sum;
        logic                found;
        dbl   = {cand, cand} >> ptr;
        rot   = dbl[NumReq-1:0];
        off   = '0;
        found = 1'b0;
        for (int unsigned j = 0; j < NumReq; j++) begin
            if (!found && rot[j]) begin
                off   = (IdxWidth+1)'(j);
                found = 1'b1;
            end
        end
        sum = {1'b0, ptr} + off;
        if (sum >= (IdxWidth+1)'(NumReq)) begin
            sum = sum - (IdxWidth+1)'(NumReq);
        end
        return sum[IdxWidth-1:0];
    endfunction

    for (genvar i = 0; i < NumReq; i++) begin : g_req
        assign w_addr[i]    = req_addr_i[i*AddrWidth +: AddrWidth];
        assign w_data[i]    = req_data_i[i*DataWidth +: DataWidth];
        assign w_strb[i]    = req_strb_i[i*StrbWidth +: StrbWidth];
        assign w_user[i]    = req_user_i[i*UserWidth +: UserWidth];
        assign w_starved[i] = (r_starve_cnt[i] == CntWidth'(MaxStarve));

        // Requester must hold valid and payload until accepted.
        a_req_stable: assert property (@(posedge clk_i) disable iff (rst_i)
            (req_valid_i[i] && !req_ready_o[i]) |=>
            (req_valid_i[i] && $stable(req_write_i[i]) &&
             $stable(req_addr_i[i*AddrWidth +: AddrWidth]) &&
             $stable(req_data_i[i*DataWidth +: DataWidth]) &&
             $stable(req_strb_i[i*StrbWidth +: StrbWidth]) &&
             $stable(req_user_i[i*UserWidth +: UserWidth])));
    end

    // Arbitration: prioritised or starved requesters first, else any valid one.
    always_comb begin
        w_cand = req_valid_i & (req_prio_i | w_starved);
        if (w_cand == '0) begin
            w_cand = req_valid_i;
        end
        w_arb_gnt = f_rr_pick(w_cand, r_rr_ptr);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            IDLE:    if (w_mem_valid && !mem_ready_i) w_state_d = HOLD;
            HOLD:    if (w_mem_valid && mem_ready_i)  w_state_d = IDLE;
            default: w_state_d = IDLE;
        endcase
    end

    // HOLD pins the grant so the bank sees a stable request under backpressure.
    always_comb begin
        w_gnt       = (r_state == HOLD) ? r_gnt_q : w_arb_gnt;
        w_mem_valid = !rst_i && ((r_state == HOLD) || (|req_valid_i));
        req_ready_o = '0;
        if (w_mem_valid && mem_ready_i) begin
            req_ready_o = NumReq'(1) << w_gnt;
        end
    end

    assign w_hs        = w_mem_valid & mem_ready_i;
    assign w_gnt_inc   = {1'b0, w_gnt} + (IdxWidth+1)'(1);
    assign mem_valid_o = w_mem_valid;
    assign mem_addr_o  = w_addr[w_gnt];
    assign mem_write_o = req_write_i[w_gnt];
    assign mem_data_o  = w_data[w_gnt];
    assign mem_strb_o  = w_strb[w_gnt];
    assign mem_user_o  = w_user[w_gnt];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_gnt_q  <= '0;
            r_rr_ptr <= '0;
        end else begin
            if (r_state == IDLE && w_state_d == HOLD) begin
                r_gnt_q <= w_gnt;
            end
            if (w_hs) begin
                r_rr_ptr <= (w_gnt_inc == (IdxWidth+1)'(NumReq)) ? '0 : w_gnt_inc[IdxWidth-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                r_starve_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NumReq; i++) begin
                if (req_ready_o[i]) begin
                    r_starve_cnt[i] <= '0;
                end else if (req_valid_i[i] && !w_starved[i]) begin
                    r_starve_cnt[i] <= r_starve_cnt[i] + CntWidth'(1);
                end
            end
        end
    end

    // Tag pipeline mirrors the bank latency so each response finds its requester.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_tag_vld <= '0;
            r_tag_idx <= '0;
        end else begin
            r_tag_vld[0] <= w_hs;
            r_tag_idx[0] <= w_hs ? w_gnt : '0;
            for (int unsigned i = 1; i < Lat; i++) begin
                r_tag_vld[i] <= r_tag_vld[i-1];
                r_tag_idx[i] <= r_tag_idx[i-1];
            end
        end
    end

    for (genvar i = 0; i < NumReq; i++) begin : g_rsp
        assign rsp_valid_o[i] = r_tag_vld[Lat-1] && (r_tag_idx[Lat-1] == IdxWidth'(i));
    end
    assign rsp_data_o = mem_rdata_i;

endmodule
